// File: rtl/bus_pkg.sv
// Shared types and defaults for the serial system bus arbiter.
package bus_pkg;

    localparam int DEF_NUM_MASTERS = 2;
    localparam int DEF_ID_W        = $clog2(DEF_NUM_MASTERS);

    typedef logic [DEF_ID_W-1:0] master_id_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT  = 2'd1,
        RESUME = 2'd2
    } arb_state_t;

endpackage

// File: rtl/arb_picker.sv
// Combinational winner selection over the eligible request vector.
// BUS_ARB_RR_EN selects round-robin (search from rr_ptr+1); otherwise lowest index wins.
module arb_picker
    import bus_pkg::*;
#(
    parameter int NUM_MASTERS = DEF_NUM_MASTERS,
    parameter int ID_W        = $clog2(NUM_MASTERS)
) (
    input  logic [NUM_MASTERS-1:0] eligible,
`ifdef BUS_ARB_RR_EN
    input  logic [ID_W-1:0]        rr_ptr,
`endif
    output logic                   valid,
    output logic [ID_W-1:0]        idx
);

`ifdef BUS_ARB_RR_EN
    // Scan from the farthest candidate back to rr_ptr+1 so the nearest one is assigned last.
    always_comb begin
        int cand;
        cand  = 0;
        valid = |eligible;
        idx   = '0;
        for (int k = NUM_MASTERS; k >= 1; k--) begin
            cand = (int'(rr_ptr) + k) % NUM_MASTERS;
            if (eligible[cand]) begin
                idx = ID_W'(cand);
            end
        end
    end
`else
    always_comb begin
        valid = |eligible;
        idx   = '0;
        for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                idx = ID_W'(i);
            end
        end
    end
`endif

endmodule

// File: rtl/bus_arbiter.sv
// Central bus arbiter: single owner grant, mux select and split-read parking/resume.
// Define BUS_ARB_RR_EN for round-robin selection; default is fixed priority.
module bus_arbiter
    import bus_pkg::*;
#(
    parameter int NUM_MASTERS = DEF_NUM_MASTERS,
    parameter int ID_W        = $clog2(NUM_MASTERS)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_MASTERS-1:0] breq,
    output logic [NUM_MASTERS-1:0] bgrant,
    output logic [NUM_MASTERS-1:0] split,
    output logic [ID_W-1:0]        msel,
    output logic                   bus_busy,
    input  logic                   split_req,
    input  logic                   split_done,
    output logic                   split_err
);

    arb_state_t             state_reg;
    logic [ID_W-1:0]        owner_reg;
    logic [ID_W-1:0]        msel_reg;
    logic [NUM_MASTERS-1:0] bgrant_reg;
    logic                   split_pend_reg;
    logic [ID_W-1:0]        split_id_reg;
    logic                   resume_rdy_reg;
    logic                   split_err_reg;

    logic [NUM_MASTERS-1:0] eligible;
    logic [NUM_MASTERS-1:0] pick_onehot;
    logic [NUM_MASTERS-1:0] split_onehot;
    logic                   pick_valid;
    logic [ID_W-1:0]        pick_idx;
    logic                   split_accept;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_MASTERS; gi++) begin : g_master
            assign split_onehot[gi] = split_pend_reg && (split_id_reg == ID_W'(gi));
            assign eligible[gi]     = breq[gi] & ~split_onehot[gi];
            assign pick_onehot[gi]  = (pick_idx == ID_W'(gi));
        end
    endgenerate

`ifdef BUS_ARB_RR_EN
    logic [ID_W-1:0] rr_ptr_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr_reg <= '0;
        end else if (state_reg == IDLE && !(split_pend_reg && resume_rdy_reg) && pick_valid) begin
            rr_ptr_reg <= pick_idx;
        end
    end
`endif

    arb_picker #(
        .NUM_MASTERS (NUM_MASTERS),
        .ID_W        (ID_W)
    ) u_picker (
        .eligible (eligible),
`ifdef BUS_ARB_RR_EN
        .rr_ptr   (rr_ptr_reg),
`endif
        .valid    (pick_valid),
        .idx      (pick_idx)
    );

    assign split_accept = (state_reg == GRANT) && split_req && !split_pend_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= IDLE;
            owner_reg      <= '0;
            msel_reg       <= '0;
            bgrant_reg     <= '0;
            split_pend_reg <= 1'b0;
            split_id_reg   <= '0;
            resume_rdy_reg <= 1'b0;
            split_err_reg  <= 1'b0;
        end else begin
            split_err_reg <= split_req && split_pend_reg;

            // A done arriving with the split being recorded this cycle still counts.
            if (split_done) begin
                if (split_pend_reg || split_accept) begin
                    resume_rdy_reg <= 1'b1;
                end else begin
                    split_err_reg <= 1'b1;
                end
            end

            case (state_reg)
                IDLE: begin
                    if (split_pend_reg && resume_rdy_reg) begin
                        state_reg      <= RESUME;
                        resume_rdy_reg <= 1'b0;
                        split_pend_reg <= 1'b0;
                        owner_reg      <= split_id_reg;
                        msel_reg       <= split_id_reg;
                        bgrant_reg     <= split_onehot;
                    end else if (pick_valid) begin
                        state_reg  <= GRANT;
                        owner_reg  <= pick_idx;
                        msel_reg   <= pick_idx;
                        bgrant_reg <= pick_onehot;
                    end
                end
                GRANT: begin
                    if (split_accept) begin
                        split_pend_reg <= 1'b1;
                        split_id_reg   <= owner_reg;
                        bgrant_reg     <= '0;
                        state_reg      <= IDLE;
                    end else if (!breq[owner_reg]) begin
                        bgrant_reg <= '0;
                        state_reg  <= IDLE;
                    end
                end
                RESUME: begin
                    state_reg <= GRANT;
                end
                default: begin
                    state_reg  <= IDLE;
                    bgrant_reg <= '0;
                end
            endcase
        end
    end

    assign bgrant    = bgrant_reg;
    assign split     = split_onehot;
    assign msel      = msel_reg;
    assign bus_busy  = |bgrant_reg;
    assign split_err = split_err_reg;

endmodule
